// File: rtl/mac_pkg.sv
// Shared types and helpers for the lane-parallel MAC: FSM states, accumulator sizing
// and output saturation.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               flag;
  } sat_t;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  // Clamp a sign-extended accumulator into an out_w-bit signed range.
  function automatic sat_t saturate(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.value = acc;
    r.flag  = 1'b0;
    if (acc > hi) begin
      r.value = hi;
      r.flag  = 1'b1;
    end else if (acc < lo) begin
      r.value = lo;
      r.flag  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational sum of LANES signed WIDTH x WIDTH products, one beat of the MAC.
import mac_pkg::*;

module mac_lane_sum #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int SUM_W = 2 * WIDTH + $clog2(LANES) + 1
) (
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] w,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [WIDTH-1:0]   xa;
  logic signed [WIDTH-1:0]   wa;
  logic signed [2*WIDTH-1:0] prod;

  // Products are formed at full 2*WIDTH before widening, so no lane can overflow.
  always_comb begin
    sum  = '0;
    xa   = '0;
    wa   = '0;
    prod = '0;
    for (int k = 0; k < LANES; k++) begin
      xa   = x[k*WIDTH +: WIDTH];
      wa   = w[k*WIDTH +: WIDTH];
      prod = xa * wa;
      sum  = sum + SUM_W'(prod);
    end
  end

endmodule

// File: rtl/mac_lanes.sv
// Handshaked N-element signed MAC, LANES products per cycle, saturating to OUT_W bits.
// Define MAC_LANES_RELU_EN to clip negative results to zero after saturation.
import mac_pkg::*;

module mac_lanes #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int OUT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] x,
  input  logic [N*WIDTH-1:0] w,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   y,
  output logic               sat
);

  localparam int ACC_W  = acc_width(WIDTH, N);
  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W  = 2 * WIDTH + $clog2(LANES) + 1;

  state_t                   state;
  logic [N*WIDTH-1:0]       x_r;
  logic [N*WIDTH-1:0]       w_r;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0]        beat;
  logic signed [SUM_W-1:0]  lane_sum;
  logic [OUT_W:0]           result;

  // Returns {flag, value}; the optional ReLU stage sits after saturation.
  function automatic logic [OUT_W:0] clamp_out(input logic signed [ACC_W-1:0] a);
    sat_t c;
    c = saturate(64'(a), OUT_W);
`ifdef MAC_LANES_RELU_EN
    if (c.value[63]) begin
      return '0;
    end
`endif
    return {c.flag, c.value[OUT_W-1:0]};
  endfunction

  mac_lane_sum #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .SUM_W(SUM_W)
  ) u_lane_sum (
    .x  (x_r[beat*LANES*WIDTH +: LANES*WIDTH]),
    .w  (w_r[beat*LANES*WIDTH +: LANES*WIDTH]),
    .sum(lane_sum)
  );

  always_comb begin
    acc_next = acc + ACC_W'(lane_sum);
    result   = clamp_out(acc_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
      beat      <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_r      <= x;
            w_r      <= w;
            acc      <= ACC_W'(signed'(b));
            beat     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          beat <= beat + 1'b1;
          if (beat == BEAT_W'(BEATS - 1)) begin
            y         <= result[OUT_W-1:0];
            sat       <= result[OUT_W];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // in_ready only returns a cycle after handoff, so no accept overlaps it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lanes.sv
// Scoreboard bench for mac_lanes (N=8, WIDTH=8, LANES=2, OUT_W=16).
module tb_mac_lanes;

  localparam int N     = 8;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int OUT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [N*WIDTH-1:0] x = '0;
  logic [N*WIDTH-1:0] w = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  y;
  logic              sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_out = -1;
  int nouts = 0;
  bit check_spacing = 1'b0;
  logic [OUT_W:0] sb[$];
  logic [OUT_W:0] popped;

  mac_lanes #(.N(N), .WIDTH(WIDTH), .LANES(LANES), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: {sat, y} from plain integer arithmetic.
  function automatic logic [OUT_W:0] model(input logic [N*WIDTH-1:0] xv,
                                           input logic [N*WIDTH-1:0] wv,
                                           input logic [WIDTH-1:0] bv);
    longint acc;
    longint hi;
    longint lo;
    acc = longint'($signed(bv));
    for (int i = 0; i < N; i++)
      acc += longint'($signed(xv[i*WIDTH +: WIDTH])) * longint'($signed(wv[i*WIDTH +: WIDTH]));
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    if (acc > hi) return {1'b1, hi[OUT_W-1:0]};
`ifdef MAC_LANES_RELU_EN
    if (acc < 0) return '0;
`endif
    if (acc < lo) return {1'b1, lo[OUT_W-1:0]};
    return {1'b0, acc[OUT_W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(x, w, b));
      if (out_valid && out_ready) begin
        nouts++;
        if (sb.size() == 0) begin
          checkOutput("sb_nonempty", sb.size(), 1);
        end else begin
          popped = sb.pop_front();
          checkOutput("y", 32'(y), 32'(popped[OUT_W-1:0]));
          checkOutput("sat", 32'(sat), 32'(popped[OUT_W]));
        end
        if (check_spacing && last_out >= 0) checkOutput("spacing", cyc - last_out, 6);
        last_out = cyc;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Accept one operand set and return cycles from the accept edge to out_valid.
  task automatic applyStimulus(input logic [N*WIDTH-1:0] xv, input logic [N*WIDTH-1:0] wv,
                               input logic [WIDTH-1:0] bv, output int lat);
    wait_ready();
    x = xv; w = wv; b = bv;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      checkOutput("busy_in_ready", 32'(in_ready), 0);
      @(posedge clk); #2;
      lat++;
    end
  endtask

  localparam logic [63:0] X_ONES = 64'h0101010101010101;
  localparam logic [63:0] W_SEQ  = 64'h0807060504030201;
  localparam logic [63:0] V_MIN  = 64'h8080808080808080;
  localparam logic [63:0] V_MAX  = 64'h7F7F7F7F7F7F7F7F;

  initial begin
    int lat;
    int n;
    int base;
    bit was_ready;
    logic [OUT_W:0] exp_bp;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_y", 32'(y), 0);
    checkOutput("rst_sat", 32'(sat), 0);

    // Basic dot product, 4-cycle latency.
    out_ready = 1'b1;
    applyStimulus(X_ONES, W_SEQ, 8'd3, lat);
    checkOutput("basic_latency", lat, 4);
    checkOutput("basic_y_direct", 32'(y), 39);
    wait_drain();

    applyStimulus(V_MIN, V_MIN, 8'h7F, lat);
    wait_drain();
    applyStimulus(V_MIN, V_MAX, 8'h80, lat);
    wait_drain();

    // Backpressure with stray in_valid pulses.
    out_ready = 1'b0;
    applyStimulus(X_ONES, W_SEQ, 8'hFB, lat);
    exp_bp = model(X_ONES, W_SEQ, 8'hFB);
    x = {8{8'h02}}; w = {8{8'h02}}; b = 8'd9;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 1);
      checkOutput("bp_y", 32'(y), 32'(exp_bp[OUT_W-1:0]));
      checkOutput("bp_sat", 32'(sat), 32'(exp_bp[OUT_W]));
      checkOutput("bp_in_ready", 32'(in_ready), 0);
      in_valid = (i % 2 == 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    checkOutput("bp_release_out_valid", 32'(out_valid), 0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 1);
    repeat (3) @(posedge clk);
    #2 checkOutput("bp_no_phantom", 32'(out_valid), 0);

    // Reset at beat 2 of RUN.
    out_ready = 1'b1;
    wait_ready();
    x = X_ONES; w = W_SEQ; b = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_y", 32'(y), 0);
    checkOutput("midrst_sat", 32'(sat), 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    applyStimulus(X_ONES, W_SEQ, 8'd3, lat);
    checkOutput("post_rst_latency", lat, 4);
    wait_drain();

    // Back-to-back with in_valid and out_ready held high.
    check_spacing = 1'b1;
    last_out = -1;
    base = nouts;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom}; w = {$urandom, $urandom}; b = 8'($urandom);
      in_valid = 1'b1;
      n = 0;
      do begin
        was_ready = in_ready;
        @(posedge clk); #2;
        n++;
      end while (!was_ready && n < 50);
    end
    in_valid = 1'b0;
    wait_drain();
    check_spacing = 1'b0;
    checkOutput("b2b_count", nouts - base, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_lanes.md
Name: mac_lanes

Overview:
- Parametrised, handshaked successor to the single-product sequential MAC. Computes y = sat(sum_i(w_i * x_i) + b) over N signed elements, LANES products per cycle.
- Sits between the vector/weight source and the activation/output stage of a neuron datapath.
- Ready/valid on both sides; result saturates to a configurable output width.

Parameters:
N, 8, vector length; must be a multiple of LANES.
WIDTH, 8, signed width of each x_i, w_i and of b.
LANES, 2, products accumulated per cycle; 1 <= LANES <= N.
OUT_W, 16, signed width of result y; OUT_W <= ACC_W.
ACC_W, 2*WIDTH+$clog2(N)+1, internal accumulator width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand set x/w/b valid
in_ready  out  1  block can accept operands (IDLE only)
x  in  N*WIDTH  signed inputs; element i at x[i*WIDTH +: WIDTH]
w  in  N*WIDTH  signed weights; same packing as x
b  in  WIDTH  signed bias
out_valid  out  1  y/sat valid
out_ready  in  1  consumer accepts y
y  out  OUT_W  saturated signed result
sat  out  1  1 if y was clamped

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, y=0, sat=0, beat=0, acc=0. Overrides all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0: register x, w, b; set acc = sign-extended b; set beat=0; go to RUN.
  - Operand ports are don't-care after capture.
- RUN:
  - in_ready=0.
  - Each edge: acc += sum over k<LANES of x[j*LANES+k]*w[j*LANES+k], with j=beat; then beat++.
  - All arithmetic is signed at full ACC_W, so no internal overflow is possible.
  - On the final beat (beat==N/LANES-1): y=clamp(final acc), sat=clamp flag, out_valid=1, go to DONE.
  - out_valid therefore rises at edge E0+N/LANES.
- Clamp rule:
  - acc > 2^(OUT_W-1)-1 gives y=2^(OUT_W-1)-1, sat=1.
  - acc < -2^(OUT_W-1) gives y=-2^(OUT_W-1), sat=1.
  - Otherwise y=acc[OUT_W-1:0], sat=0.
- DONE:
  - y, sat and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0, go to IDLE. y and sat keep their last values.
  - in_ready=0 in DONE; inputs are not accepted in the same cycle as output handoff.
- Throughput: one result per N/LANES+2 cycles when in_valid=out_ready=1 are held.
- in_valid outside IDLE is ignored; there is no queuing.
- rst mid-RUN or mid-DONE: the operation is aborted, the result is lost, and the reset values apply on the next cycle.
- Degenerate case LANES==N: RUN lasts one cycle.

Optional Feature:
MAC_LANES_RELU_EN
- Defined:
  - y = max(0, clamp(acc)).
  - Negative acc gives y=0, sat=0.
  - Positive overflow still gives y=2^(OUT_W-1)-1, sat=1.
- Undefined: plain signed saturation as above.
- Latency is identical in both builds.

Decomposition:
- Package mac_pkg:
  - State enum (IDLE, RUN, DONE).
  - acc_width function (2*w + clog2(n) + 1).
  - Saturation helper function returning the clamped value and flag.
- Sub-module mac_lane_sum: combinational sum of LANES signed WIDTH×WIDTH products, output 2*WIDTH+$clog2(LANES)+1 bits, instantiated once in the RUN datapath.
- FSM, operand registers, accumulator and output registers stay in mac_lanes.

Test Plan:
All scenarios use N=8, WIDTH=8, LANES=2, OUT_W=16.
1. Basic: x_i=1, w_i=i+1 (1..8), b=3, out_ready=1. Required: y=39, sat=0, out_valid rises exactly 4 cycles after the accept edge, and in_ready=0 throughout.
2. Positive saturation: all x=-128, all w=-128, b=127 (acc=131199). Required: y=32767, sat=1.
3. Negative saturation: all x=-128, all w=127, b=-128 (acc=-130176).
   - Without macro: y=-32768, sat=1.
   - With MAC_LANES_RELU_EN: y=0, sat=0.
4. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid pulsed meanwhile. Required: y, sat and out_valid stay stable, in_ready=0, and the extra in_valid pulses are not captured. After out_ready=1 for one cycle: out_valid=0, in_ready=1.
5. Reset mid-operation: assert rst at beat 2 of RUN. Required: next cycle IDLE with out_valid=0, y=0, sat=0, in_ready=1. A following scenario-1 operation still returns y=39.
6. Back-to-back: in_valid and out_ready held 1 over 3 different operand sets. Required: 3 correct results, spaced 6 cycles apart.
